// File: rtl/fir_seq_ctrl.sv
// Sequencer for a time-multiplexed FIR: fills a circular sample buffer, then walks
// all DEPTH taps through a shared MAC, waits out its pipeline and offers the result.
module fir_seq_ctrl #(
  parameter  int DEPTH   = 200,
  parameter  int N       = 3,
  parameter  int MAC_LAT = 3,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          flush,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [N-1:0]  wr_data,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] tap_idx,
  output logic          acc_clear,
  output logic          acc_en,
  output logic          res_valid,
  input  logic          res_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [2:0] {FILL, IDLE, RUN, DRAIN, HOLD} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wp, base, k, rd_hold, tap_hold, rd_cur;
  logic [AW:0]   addr_sum;
  logic [CW-1:0] fill_cnt;
  logic [DW-1:0] drain_cnt;
  logic          accept, run_act;

  // Explicit compare-and-wrap so non-power-of-two depths never alias.
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] x);
    return (x == LAST) ? '0 : x + 1'b1;
  endfunction

  always_comb begin
    addr_sum = {1'b0, base} + {1'b0, k};
    if (addr_sum >= (AW+1)'(DEPTH)) addr_sum = addr_sum - (AW+1)'(DEPTH);
  end
  assign rd_cur = addr_sum[AW-1:0];

  // NOTE: every branch starts from a default, otherwise synthesis infers a latch.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (accept && fill_cnt == CW'(DEPTH - 1)) state_nxt = RUN;
        IDLE:    if (accept) state_nxt = RUN;
        RUN:     if (k == LAST) state_nxt = DRAIN;
        DRAIN:   if (drain_cnt == DW'(MAC_LAT - 1)) state_nxt = HOLD;
        HOLD:    if (res_ready) state_nxt = IDLE;
        default: state_nxt = FILL;
      endcase
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp        <= '0;
      fill_cnt  <= '0;
      k         <= '0;
      base      <= '0;
      drain_cnt <= '0;
      rd_hold   <= '0;
      tap_hold  <= '0;
    end else begin
      if (flush) begin
        wp       <= '0;
        fill_cnt <= '0;
        k        <= '0;
      end else begin
        if (accept) wp <= wrap_inc(wp);
        if (accept && state == FILL) fill_cnt <= fill_cnt + 1'b1;
        // The updated write pointer is the oldest sample, i.e. tap 0 of this run.
        if (state != RUN && state_nxt == RUN) begin
          base <= wrap_inc(wp);
          k    <= '0;
        end else if (state == RUN && k != LAST) begin
          k <= k + 1'b1;
        end
      end
      if (state == DRAIN && state_nxt == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                                      drain_cnt <= '0;
      if (run_act) begin
        rd_hold  <= rd_cur;
        tap_hold <= k;
      end
    end
  end

  always_comb begin
    in_ready  = (state == FILL) || (state == IDLE);
    accept    = in_valid && in_ready && !flush && !rst;
    run_act   = (state == RUN) && !flush;
    wr_en     = accept;
    wr_addr   = wp;
    wr_data   = in_data;
    acc_en    = run_act;
    acc_clear = run_act && (k == '0);
    rd_addr   = run_act ? rd_cur : rd_hold;
    tap_idx   = run_act ? k : tap_hold;
    res_valid = (state == HOLD) && !flush;
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Randomised scoreboard bench for fir_seq_ctrl: a timeline model predicts write,
// tap-walk and result events; a negedge monitor pops and compares them.
module tb_fir_seq_ctrl;

  localparam int DEPTH   = 5;
  localparam int N       = 3;
  localparam int MAC_LAT = 2;
  localparam int AW      = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, flush, wr_en, acc_clear, acc_en, res_valid, res_ready;
  logic [N-1:0]  in_data, wr_data;
  logic [AW-1:0] wr_addr, rd_addr, tap_idx;

  fir_seq_ctrl #(.DEPTH(DEPTH), .N(N), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .tap_idx(tap_idx), .acc_clear(acc_clear), .acc_en(acc_en),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int addr; int tap; bit clr; } acc_t;

  wr_t  wr_q[$];
  acc_t acc_q[$];
  int   res_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit started  = 0;

  // Reference model: samples since last clear, write slot, and when a pending result appears.
  bit m_active    = 0;
  int m_filled    = 0;
  int m_wp        = 0;
  int m_hold_from = 0;
  bit exp_ready_c = 1;
  bit exp_rv_c    = 0;
  int last_rd     = 0;
  int last_tap    = 0;
  bit prev_rv     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_active = 0;
    m_filled = 0;
    m_wp     = 0;
    acc_q.delete();
    res_q.delete();
  endtask

  task automatic model_cycle(input bit v, input logic [N-1:0] d, input bit rr, input bit fl);
    int c;
    int base;
    c = cyc;
    exp_ready_c = !m_active;
    exp_rv_c    = m_active && (c >= m_hold_from) && !fl;
    if (fl) begin
      model_clear();
    end else begin
      if (exp_rv_c && rr) m_active = 0;
      if (v && exp_ready_c) begin
        wr_q.push_back('{m_wp, int'(d)});
        m_wp = (m_wp + 1) % DEPTH;
        if (m_filled < DEPTH) m_filled++;
        if (m_filled == DEPTH) begin
          m_active    = 1;
          m_hold_from = c + DEPTH + MAC_LAT + 1;
          base        = m_wp;
          for (int j = 0; j < DEPTH; j++) acc_q.push_back('{(base + j) % DEPTH, j, j == 0});
          res_q.push_back(m_hold_from);
        end
      end
    end
  endtask

  task automatic step(input bit v, input logic [N-1:0] d, input bit rr, input bit fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    res_ready = rr;
    flush     = fl;
    model_cycle(v, d, rr, fl);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready, 1);
    check({tag, "_wr_en"},     wr_en, 0);
    check({tag, "_acc_en"},    acc_en, 0);
    check({tag, "_acc_clear"}, acc_clear, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_rd_addr"},   rd_addr, 0);
    check({tag, "_tap_idx"},   tap_idx, 0);
  endtask

  // Reset pulse placed between clock edges, with a sample offered while it is high.
  task automatic async_reset_pulse();
    @(posedge clk);
    #1;
    in_valid  = 1;
    flush     = 0;
    res_ready = 0;
    #1 rst = 1;
    #1 check_reset_outputs("async_rst");
    in_valid = 0;
    model_clear();
    exp_ready_c = 1;
    exp_rv_c    = 0;
    last_rd     = 0;
    last_tap    = 0;
    prev_rv     = 0;
    #1 rst = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && started) begin
      check("in_ready", in_ready, exp_ready_c);
      check("res_valid", res_valid, exp_rv_c);
      if (wr_en) begin
        if (wr_q.size() == 0) check("wr_unexpected", wr_en, 0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", wr_addr, w.addr);
          check("wr_data", wr_data, w.data);
        end
      end
      if (acc_en) begin
        if (acc_q.size() == 0) check("acc_unexpected", acc_en, 0);
        else begin
          acc_t a;
          a = acc_q.pop_front();
          check("rd_addr", rd_addr, a.addr);
          check("tap_idx", tap_idx, a.tap);
          check("acc_clear", acc_clear, a.clr);
          last_rd  = a.addr;
          last_tap = a.tap;
        end
      end else begin
        check("acc_clear_idle", acc_clear, 0);
        check("rd_addr_hold", rd_addr, last_rd);
        check("tap_idx_hold", tap_idx, last_tap);
      end
      if (res_valid && !prev_rv) begin
        if (res_q.size() == 0) check("res_unexpected", res_valid, 0);
        else check("res_latency_cycle", cyc, res_q.pop_front());
      end
      prev_rv = res_valid;
    end
  end

  initial begin
    bit hit;
    rst = 1; in_valid = 0; in_data = '0; flush = 0; res_ready = 0;
    #3 check_reset_outputs("init_rst");
    repeat (2) @(posedge clk);
    #1 rst = 0;
    started = 1;

    // Free-flowing, heavy back-pressure, then mixed handshakes; rare flushes throughout.
    for (int i = 0; i < 1500; i++) begin
      bit rr;
      if (i < 500)       rr = 1;
      else if (i < 1000) rr = ($urandom_range(0, 15) == 0);
      else               rr = $urandom_range(0, 1) != 0;
      step($urandom_range(0, 3) != 0, N'($urandom), rr, $urandom_range(0, 99) == 0);
    end

    hit = 0;
    for (int i = 0; i < 300; i++) begin
      if (m_active && cyc + 1 == m_hold_from - MAC_LAT) begin hit = 1; break; end
      step($urandom_range(0, 1) != 0, N'($urandom), 1, 0);
    end
    check("reached_drain", hit, 1);
    async_reset_pulse();

    hit = 0;
    for (int i = 0; i < 300; i++) begin
      if (m_active && cyc + 1 == m_hold_from - MAC_LAT - DEPTH + 2) begin hit = 1; break; end
      step($urandom_range(0, 1) != 0, N'($urandom), 1, 0);
    end
    check("reached_run_k2", hit, 1);
    step(1, N'($urandom), 1, 1);

    for (int i = 0; i < 200; i++) step($urandom_range(0, 2) != 0, N'($urandom), $urandom_range(0, 1) != 0, 0);
    repeat (DEPTH + MAC_LAT + 20) step(0, '0, 1, 0);
    @(negedge clk);
    #1;
    check("wr_q_empty", wr_q.size(), 0);
    check("acc_q_empty", acc_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
